// File: rtl/leaf_packet_tx_pkg.sv
// Shared BFT leaf definitions: packet field widths, packet layout and transmit FSM encoding.
package leaf_packet_tx_pkg;

  localparam int unsigned PAYLOAD_W    = 32;
  localparam int unsigned LEAF_W       = 5;
  localparam int unsigned PORT_W       = 4;
  localparam int unsigned ADDR_W       = 7;
  localparam int unsigned PACKET_W     = 1 + LEAF_W + PORT_W + ADDR_W + PAYLOAD_W;
  localparam int unsigned CREDIT_W     = 9;
  localparam int unsigned UPD_W        = 8;
  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned INIT_CRED_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_HOLD = 2'b10
  } tx_state_e;

  // Field order gives bit positions: vld[48] leaf[47:43] port[42:39] addr[38:32] payload[31:0]
  typedef struct packed {
    logic                 vld;
    logic [LEAF_W-1:0]    leaf;
    logic [PORT_W-1:0]    port;
    logic [ADDR_W-1:0]    addr;
    logic [PAYLOAD_W-1:0] payload;
  } packet_t;

endpackage

// File: rtl/leaf_packet_tx_if.sv
// User-side word handshake, credit return and BFT-side packet bus of the leaf transmitter.
interface leaf_packet_tx_if
  import leaf_packet_tx_pkg::*;
#(
  parameter int unsigned PACKET_BITS   = PACKET_W,
  parameter int unsigned PAYLOAD_BITS  = PAYLOAD_W,
  parameter int unsigned NUM_LEAF_BITS = LEAF_W,
  parameter int unsigned NUM_PORT_BITS = PORT_W
) ();

  logic [PAYLOAD_BITS-1:0]  din_leaf_user2interface;
  logic                     vld_user2interface;
  logic                     ack_interface2user;
  logic [NUM_LEAF_BITS-1:0] dest_leaf;
  logic [NUM_PORT_BITS-1:0] dest_port;
  logic                     credit_upd_vld;
  logic [UPD_W-1:0]         credit_upd_cnt;
  logic                     resend;
  logic [PACKET_BITS-1:0]   dout_leaf_interface2bft;

  modport master (
    output din_leaf_user2interface, vld_user2interface, dest_leaf, dest_port,
    output credit_upd_vld, credit_upd_cnt, resend,
    input  ack_interface2user, dout_leaf_interface2bft
  );

  modport slave (
    input  din_leaf_user2interface, vld_user2interface, dest_leaf, dest_port,
    input  credit_upd_vld, credit_upd_cnt, resend,
    output ack_interface2user, dout_leaf_interface2bft
  );

endinterface

// File: rtl/leaf_tx_fifo.sv
// First-word-fall-through FIFO holding {leaf, port, payload} entries awaiting transmission.
module leaf_tx_fifo #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/leaf_packet_tx.sv
// Leaf packet transmitter: queues user words, tags them with a rolling address and sends them
// onto the BFT under receiver credit control, re-driving a packet while the receiver drops it.
module leaf_packet_tx
  import leaf_packet_tx_pkg::*;
#(
  parameter int unsigned PACKET_BITS   = PACKET_W,
  parameter int unsigned PAYLOAD_BITS  = PAYLOAD_W,
  parameter int unsigned NUM_LEAF_BITS = LEAF_W,
  parameter int unsigned NUM_PORT_BITS = PORT_W,
  parameter int unsigned NUM_ADDR_BITS = ADDR_W,
  parameter int unsigned INIT_CREDITS  = INIT_CRED_DEF
) (
  input  logic            clk,
  input  logic            reset,
  leaf_packet_tx_if.slave bus
);

  localparam int unsigned ENTRY_W = PAYLOAD_BITS + NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int unsigned SUM_W   = CREDIT_W + 1;

  tx_state_e                state_q, state_d;
  logic [CREDIT_W-1:0]      credits_q, credits_d;
  logic [SUM_W-1:0]         credit_sum;
  logic [NUM_ADDR_BITS-1:0] wptr_q;
  logic [PACKET_BITS-1:0]   out_q, out_d;
  logic [ENTRY_W-1:0]       head, entry_in;
  logic                     fifo_empty, fifo_full;
  logic                     can_send, send, push;
  packet_t                  pkt;

  assign entry_in = {bus.dest_leaf, bus.dest_port, bus.din_leaf_user2interface};
  assign can_send = !fifo_empty && (credits_q != '0);
  // A full FIFO may still accept when the head leaves in the same cycle.
  assign push     = !reset && bus.vld_user2interface && (!fifo_full || send);

  assign bus.ack_interface2user      = push;
  assign bus.dout_leaf_interface2bft = out_q;

  leaf_tx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (entry_in),
    .pop   (send),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // State register: IDLE = bus empty, SEND = fresh packet on bus, HOLD = packet being re-driven.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (can_send) state_d = ST_SEND;
      ST_SEND, ST_HOLD: begin
        if (bus.resend)    state_d = ST_HOLD;
        else if (can_send) state_d = ST_SEND;
        else               state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    send  = 1'b0;
    out_d = '0;
    pkt.vld     = 1'b1;
    pkt.leaf    = LEAF_W'(head[ENTRY_W-1 -: NUM_LEAF_BITS]);
    pkt.port    = PORT_W'(head[PAYLOAD_BITS +: NUM_PORT_BITS]);
    pkt.addr    = ADDR_W'(wptr_q);
    pkt.payload = PAYLOAD_W'(head[PAYLOAD_BITS-1:0]);
    unique case (state_q)
      ST_IDLE: send = can_send;
      ST_SEND, ST_HOLD: begin
        if (bus.resend) out_d = out_q;
        else            send  = can_send;
      end
      default: send = 1'b0;
    endcase
    if (send) out_d = PACKET_BITS'(pkt);
  end

  // Credits: one spent per fresh packet, returns added, capped at the receiver buffer size.
  assign credit_sum = SUM_W'(credits_q) - SUM_W'(send)
                    + (bus.credit_upd_vld ? SUM_W'(bus.credit_upd_cnt) : SUM_W'(0));
  assign credits_d  = (credit_sum > SUM_W'(INIT_CREDITS)) ? CREDIT_W'(INIT_CREDITS)
                                                          : credit_sum[CREDIT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q     <= '0;
      wptr_q    <= '0;
      credits_q <= CREDIT_W'(INIT_CREDITS);
    end else begin
      out_q     <= out_d;
      credits_q <= credits_d;
      if (send) wptr_q <= wptr_q + NUM_ADDR_BITS'(1);
    end
  end

endmodule

// File: tb/tb_leaf_packet_tx.sv
// Directed and randomized checks of leaf_packet_tx against a queue-based transaction model.
module tb_leaf_packet_tx;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  l;
    logic [3:0]  p;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leaf_packet_tx_if bus ();

  leaf_packet_tx #(
    .PACKET_BITS   (49),
    .PAYLOAD_BITS  (32),
    .NUM_LEAF_BITS (5),
    .NUM_PORT_BITS (4),
    .NUM_ADDR_BITS (7),
    .INIT_CREDITS  (128)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model: waiting words, credit balance, next address, packet expected on the bus
  ent_t        q[$];
  int          credits = 128;
  int          wptr    = 0;
  logic [48:0] exp_bus = '0;

  int          checks = 0;
  int          errors = 0;
  logic        obs_ack;
  logic [48:0] prev_dout = '0;
  int          pkt_cnt, first_addr, cnt5, nxt, rs_left;
  int          starts[$];
  bit          trig, done;
  logic        uv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] l, input logic [3:0] p,
                      input logic upd, input logic [7:0] uc, input logic rs, input logic rst);
    logic        pop, exp_ack;
    ent_t        e;
    logic [48:0] dv;
    @(negedge clk);
    reset                       = rst;
    bus.vld_user2interface      = v;
    bus.din_leaf_user2interface = d;
    bus.dest_leaf               = l;
    bus.dest_port               = p;
    bus.credit_upd_vld          = upd;
    bus.credit_upd_cnt          = uc;
    bus.resend                  = rs;
    #1;
    pop     = !rst && !(exp_bus[48] && rs) && (q.size() > 0) && (credits > 0);
    exp_ack = !rst && v && ((q.size() < 4) || pop);
    obs_ack = bus.ack_interface2user;
    chk("ack", 64'(obs_ack), 64'(exp_ack));
    if (rst) begin
      q.delete();
      credits = 128;
      wptr    = 0;
      exp_bus = '0;
    end else begin
      if (!(exp_bus[48] && rs)) begin
        if (pop) begin
          e       = q.pop_front();
          exp_bus = {1'b1, e.l, e.p, 7'(wptr), e.d};
          wptr    = (wptr + 1) % 128;
        end else begin
          exp_bus = '0;
        end
      end
      if (exp_ack) begin
        e.d = d; e.l = l; e.p = p;
        q.push_back(e);
      end
      credits = credits - (pop ? 1 : 0) + (upd ? int'(uc) : 0);
      if (credits > 128) credits = 128;
    end
    @(posedge clk);
    #1;
    dv = bus.dout_leaf_interface2bft;
    chk("dout", 64'(dv), 64'(exp_bus));
    if (dv[48]) begin
      if (dv[38:32] == 7'd5) cnt5++;
      if (!prev_dout[48] || (prev_dout[38:32] != dv[38:32])) begin
        if (pkt_cnt == 0) first_addr = int'(dv[38:32]);
        pkt_cnt++;
        starts.push_back(int'(dv[38:32]));
      end
    end
    prev_dout = dv;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, $urandom(), 5'($urandom()), 4'($urandom()), 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, $urandom(), '0, '0, 1'b1, 8'd7, 1'b0, 1'b1);
    pkt_cnt = 0;
    starts.delete();
  endtask

  initial begin
    reset = 1'b1;
    bus.vld_user2interface = 1'b0;
    bus.din_leaf_user2interface = '0;
    bus.dest_leaf = '0;
    bus.dest_port = '0;
    bus.credit_upd_vld = 1'b0;
    bus.credit_upd_cnt = '0;
    bus.resend = 1'b0;
    pkt_cnt = 0; first_addr = -1; cnt5 = 0;

    // Reset state, ack held low while in reset
    do_reset();
    do_reset();
    chk("reset_dout", 64'(bus.dout_leaf_interface2bft), 64'(0));

    // Single word reaches the bus two cycles after acceptance
    step(1'b1, 32'hDEADBEEF, 5'd3, 4'd1, 1'b0, '0, 1'b0, 1'b0);
    idle(1);
    chk("single_pkt", 64'(bus.dout_leaf_interface2bft), 64'({1'b1, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF}));
    idle(2);
    chk("single_then_idle", 64'(bus.dout_leaf_interface2bft), 64'(0));

    // Continuous stream exhausts the initial credits, then the FIFO fills
    do_reset();
    stream(140);
    chk("exhaust_count", 64'(pkt_cnt), 64'(128));
    chk("exhaust_last_addr", 64'(starts[$]), 64'(127));
    chk("exhaust_dout_zero", 64'(bus.dout_leaf_interface2bft), 64'(0));
    chk("exhaust_ack_low", 64'(obs_ack), 64'(0));

    // Credit return at zero credits resumes sending next cycle with wrapped address
    pkt_cnt = 0; starts.delete();
    step(1'b1, $urandom(), 5'($urandom()), 4'($urandom()), 1'b1, 8'd64, 1'b0, 1'b0);
    stream(1);
    chk("resume_next_cycle", 64'(bus.dout_leaf_interface2bft[48]), 64'(1));
    stream(80);
    chk("refill_count", 64'(pkt_cnt), 64'(64));
    chk("refill_first_addr", 64'(first_addr), 64'(0));

    // Resend for three cycles on the packet with address 5
    do_reset();
    cnt5 = 0; trig = 1'b0; rs_left = 0;
    for (int i = 0; i < 150; i++) begin
      step(1'b1, $urandom(), 5'($urandom()), 4'($urandom()), 1'b0, '0, rs_left > 0, 1'b0);
      if (rs_left > 0) rs_left--;
      if (!trig && bus.dout_leaf_interface2bft[48] && (bus.dout_leaf_interface2bft[38:32] == 7'd5)) begin
        trig = 1'b1;
        rs_left = 3;
      end
    end
    nxt = -1;
    for (int i = 0; i + 1 < starts.size(); i++) if (starts[i] == 5) nxt = starts[i+1];
    chk("hold_cycles", 64'(cnt5), 64'(4));
    chk("addr_after_hold", 64'(nxt), 64'(6));
    chk("hold_credit_once", 64'(pkt_cnt), 64'(128));

    // Credit return concurrent with a send at 120 credits saturates at 128
    do_reset();
    done = 1'b0;
    for (int i = 0; i < 160; i++) begin
      uv = !done && (credits == 120) && (q.size() > 0);
      if (uv) done = 1'b1;
      step(1'b1, $urandom(), 5'($urandom()), 4'($urandom()), uv, 8'd10, 1'b0, 1'b0);
    end
    chk("saturate_count", 64'(pkt_cnt), 64'(137));

    // Reset while holding a packet with three words queued
    do_reset();
    stream(1);
    idle(1);
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom(), 5'($urandom()), 4'($urandom()), 1'b0, '0, 1'b1, 1'b0);
    step(1'b1, $urandom(), '0, '0, 1'b0, '0, 1'b1, 1'b1);
    chk("reset_hold_dout", 64'(bus.dout_leaf_interface2bft), 64'(0));
    pkt_cnt = 0; starts.delete();
    stream(140);
    chk("post_reset_first_addr", 64'(first_addr), 64'(0));
    chk("post_reset_credits", 64'(pkt_cnt), 64'(128));

    // Randomized traffic with resends, credit returns and occasional reset
    for (int i = 0; i < 400; i++)
      step(($urandom() % 4) != 0, $urandom(), 5'($urandom()), 4'($urandom()),
           ($urandom() % 6) == 0, 8'($urandom() % 32), ($urandom() % 5) == 0,
           ($urandom() % 100) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
